// File: rtl/ppu_ctrl_pkg.sv
// Shared types and constants for the PPU pipeline hazard controller.
package ppu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one ID source register: youngest non-load
// producer wins, register 0 is never forwarded.
module fwd_select
  import ppu_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_en,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_en,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      // A load in EX has no data yet; that case is covered by the stall.
      if (ex_rf_en && !ex_load && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_rf_en && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_rf_en && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage PPU: stage load enables, bubble insertion,
// branch target select, operand forwarding and stall accounting.
module pipeline_hazard_ctrl
  import ppu_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_branch_instr,
  input  logic                   id_branch_taken,
  input  logic [REG_AW-1:0]      ex_rd,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic                   ex_rf_en,
  input  logic                   mem_rf_en,
  input  logic                   wb_rf_en,
  input  logic                   ex_load,
  input  logic                   mem_load,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_ld,
  output logic                   npc_ld,
  output logic                   ifid_ld,
  output logic                   exmem_ld,
  output logic                   memwb_ld,
  output logic                   ctrl_nop_s,
  output logic                   ta_sel,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   mem_error,
  output logic [1:0]             dbg_state
);

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   mem_error_q, mem_error_d;

  logic       hz_rs, hz_rt, hz;
  logic       mem_stall, timeout, release_pipe;
  logic       fetch_ld, back_ld, nop_s;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Data-memory handshake: an access issued with mem_req completes in the
  // cycle mem_ready is high; mem_req with mem_ready low freezes the whole pipe.
  assign mem_stall = mem_req && !mem_ready;

  assign hz_rs = (id_rs != '0) && id_use_rs &&
                 ((ex_load && ex_rf_en && (ex_rd == id_rs)) ||
                  (id_branch_instr && ex_rf_en && (ex_rd == id_rs)) ||
                  (id_branch_instr && mem_load && mem_rf_en && (mem_rd == id_rs)));

  assign hz_rt = (id_rt != '0) && id_use_rt &&
                 ((ex_load && ex_rf_en && (ex_rd == id_rt)) ||
                  (id_branch_instr && ex_rf_en && (ex_rd == id_rt)) ||
                  (id_branch_instr && mem_load && mem_rf_en && (mem_rd == id_rt)));

  assign hz = hz_rs || hz_rt;

  // wait_cnt_q holds the number of frozen cycles already spent on this access.
  assign timeout = (state_q == ST_MEM_WAIT) &&
                   (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1));

  assign release_pipe = (state_q == ST_MEM_WAIT) ? (mem_ready || timeout) : !mem_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          state_d    = hz ? ST_LU_STALL : ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready || timeout) begin
          state_d    = hz ? ST_LU_STALL : ST_RUN;
          wait_cnt_d = '0;
          if (!mem_ready) begin
            mem_error_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    fetch_ld = 1'b0;
    back_ld  = 1'b0;
    nop_s    = 1'b0;
    if (reset) begin
      nop_s = 1'b1;
    end else if (release_pipe) begin
      if (hz) begin
        back_ld = 1'b1;
        nop_s   = 1'b1;
      end else begin
        fetch_ld = 1'b1;
        back_ld  = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!fetch_ld && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_rs (
    .src       (id_rs),
    .ex_rd     (ex_rd),
    .ex_rf_en  (ex_rf_en),
    .ex_load   (ex_load),
    .mem_rd    (mem_rd),
    .mem_rf_en (mem_rf_en),
    .wb_rd     (wb_rd),
    .wb_rf_en  (wb_rf_en),
    .sel       (fwd_a_raw)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_rt (
    .src       (id_rt),
    .ex_rd     (ex_rd),
    .ex_rf_en  (ex_rf_en),
    .ex_load   (ex_load),
    .mem_rd    (mem_rd),
    .mem_rf_en (mem_rf_en),
    .wb_rd     (wb_rd),
    .wb_rf_en  (wb_rf_en),
    .sel       (fwd_b_raw)
  );

  assign pc_ld      = fetch_ld;
  assign npc_ld     = fetch_ld;
  assign ifid_ld    = fetch_ld;
  assign exmem_ld   = back_ld;
  assign memwb_ld   = back_ld;
  assign ctrl_nop_s = nop_s;
  // The delay slot always executes, so the target is only taken when nPC loads.
  assign ta_sel     = id_branch_instr && id_branch_taken && fetch_ld;
  assign fwd_a_sel  = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b_sel  = reset ? FWD_RF : fwd_b_raw;
  assign stall_cnt  = stall_cnt_q;
  assign mem_error  = mem_error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: hand-computed per-cycle
// expectations are queued by the driver and checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int SCW    = 16;
  localparam int W      = 30;

  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] LUS = 2'd1;
  localparam logic [1:0] MW  = 2'd2;

  localparam logic [4:0] L_ALL = 5'b11111;
  localparam logic [4:0] L_FS  = 5'b00011;
  localparam logic [4:0] L_FZ  = 5'b00000;

  localparam logic [W-1:0] M_ALL   = {2'b11, 5'h1f, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 16'hffff};
  localparam logic [W-1:0] M_NOFWD = {2'b11, 5'h1f, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 16'hffff};

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_branch_instr, id_branch_taken;
  logic ex_rf_en, mem_rf_en, wb_rf_en, ex_load, mem_load, mem_req, mem_ready;
  logic pc_ld, npc_ld, ifid_ld, exmem_ld, memwb_ld, ctrl_nop_s, ta_sel, mem_error;
  logic [1:0] fwd_a_sel, fwd_b_sel, dbg_state;
  logic [SCW-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .STALL_CNT_W(SCW), .MEM_TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_branch_instr (id_branch_instr),
    .id_branch_taken (id_branch_taken),
    .ex_rd           (ex_rd),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .ex_rf_en        (ex_rf_en),
    .mem_rf_en       (mem_rf_en),
    .wb_rf_en        (wb_rf_en),
    .ex_load         (ex_load),
    .mem_load        (mem_load),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_ld           (pc_ld),
    .npc_ld          (npc_ld),
    .ifid_ld         (ifid_ld),
    .exmem_ld        (exmem_ld),
    .memwb_ld        (memwb_ld),
    .ctrl_nop_s      (ctrl_nop_s),
    .ta_sel          (ta_sel),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_cnt       (stall_cnt),
    .mem_error       (mem_error),
    .dbg_state       (dbg_state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int errors = 0;
  int checks = 0;

  logic [W-1:0] act;
  assign act = {dbg_state, pc_ld, npc_ld, ifid_ld, exmem_ld, memwb_ld, ctrl_nop_s,
                ta_sel, fwd_a_sel, fwd_b_sel, mem_error, stall_cnt};

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [4:0] ld,
                                      input logic nop, input logic ta,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic merr, input logic [15:0] sc);
    return {st, ld, nop, ta, fa, fb, merr, sc};
  endfunction

  logic [W-1:0] mon_e, mon_m;
  string        mon_n;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_m = mask_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if ((act & mon_m) !== (mon_e & mon_m)) begin
        errors++;
        $display("FAIL %s: actual %h required %h (care mask %h) at %0t",
                 mon_n, act, mon_e, mon_m, $time);
      end
    end
  end

  // Driver tasks
  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch_instr = 1'b0; id_branch_taken = 1'b0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_rf_en = 1'b0; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
    ex_load = 1'b0; mem_load = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step(input string nm, input logic [W-1:0] e, input bit fwd_care);
    exp_q.push_back(e);
    mask_q.push_back(fwd_care ? M_ALL : M_NOFWD);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic ex_load_hz();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset overrides a live hazard and forwarding match
    ex_rf_en = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    id_branch_instr = 1'b1; id_branch_taken = 1'b1;
    step("reset_outputs", mk(RUN, L_FZ, 1, 0, 0, 0, 0, 0), 1);
    reset = 1'b0;
    idle(); step("idle", mk(RUN, L_ALL, 0, 0, 0, 0, 0, 0), 1);

    // Memory wait: four frozen cycles, then release
    for (int i = 0; i < 4; i++) begin
      idle(); mem_req = 1'b1;
      step("mem_wait", mk((i == 0) ? RUN : MW, L_FZ, 0, 0, 0, 0, 0, 16'(i)), 1);
    end
    idle(); mem_req = 1'b1; mem_ready = 1'b1;
    step("mem_release", mk(MW, L_ALL, 0, 0, 0, 0, 0, 4), 1);

    // Load-use: single bubble, then forward from MEM
    idle(); ex_load_hz(); step("lu_stall", mk(RUN, L_FS, 1, 0, 0, 0, 0, 4), 0);
    idle(); mem_load = 1'b1; mem_rf_en = 1'b1; mem_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    step("lu_resume", mk(LUS, L_ALL, 0, 0, 2'b10, 0, 0, 5), 1);
    idle(); step("lu_after", mk(RUN, L_ALL, 0, 0, 0, 0, 0, 5), 1);

    // Chained stalls
    idle(); ex_load_hz(); step("chain_1", mk(RUN, L_FS, 1, 0, 0, 0, 0, 5), 0);
    idle(); ex_load_hz(); step("chain_2", mk(LUS, L_FS, 1, 0, 0, 0, 0, 6), 0);
    idle(); step("chain_end", mk(LUS, L_ALL, 0, 0, 0, 0, 0, 7), 1);

    // Forwarding priority
    idle(); ex_rf_en = 1'b1; ex_rd = 5'd3; mem_rf_en = 1'b1; mem_rd = 5'd3; id_rt = 5'd3; id_use_rt = 1'b1;
    step("fwd_b_ex", mk(RUN, L_ALL, 0, 0, 0, 2'b01, 0, 7), 1);
    ex_rf_en = 1'b0;
    step("fwd_b_mem", mk(RUN, L_ALL, 0, 0, 0, 2'b10, 0, 7), 1);
    idle(); ex_rf_en = 1'b1; mem_rf_en = 1'b1; id_use_rt = 1'b1;
    step("fwd_r0", mk(RUN, L_ALL, 0, 0, 0, 0, 0, 7), 1);
    idle(); wb_rf_en = 1'b1; wb_rd = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
    step("fwd_a_wb", mk(RUN, L_ALL, 0, 0, 2'b11, 0, 0, 7), 1);
    idle(); ex_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
    ex_rd = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9;
    id_use_rs = 1'b1; id_use_rt = 1'b1;
    step("fwd_all_ex", mk(RUN, L_ALL, 0, 0, 2'b01, 2'b01, 0, 7), 1);
    idle(); ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd9; mem_rf_en = 1'b1; mem_rd = 5'd9;
    id_rs = 5'd9; id_rt = 5'd9;
    step("fwd_skip_load", mk(RUN, L_ALL, 0, 0, 2'b10, 2'b10, 0, 7), 1);

    // Branches
    idle(); id_branch_instr = 1'b1; id_branch_taken = 1'b1;
    step("br_taken", mk(RUN, L_ALL, 0, 1, 0, 0, 0, 7), 1);
    id_branch_taken = 1'b0;
    step("br_not_taken", mk(RUN, L_ALL, 0, 0, 0, 0, 0, 7), 1);
    idle(); id_branch_instr = 1'b1; id_branch_taken = 1'b1;
    mem_load = 1'b1; mem_rf_en = 1'b1; mem_rd = 5'd6; id_rs = 5'd6; id_use_rs = 1'b1;
    step("br_mem_load_hz", mk(RUN, L_FS, 1, 0, 0, 0, 0, 7), 0);
    idle(); id_branch_instr = 1'b1; id_branch_taken = 1'b1;
    wb_rf_en = 1'b1; wb_rd = 5'd6; id_rs = 5'd6; id_use_rs = 1'b1;
    step("br_after_stall", mk(LUS, L_ALL, 0, 1, 2'b11, 0, 0, 8), 1);
    idle(); id_branch_instr = 1'b1; id_branch_taken = 1'b1;
    ex_rf_en = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_use_rt = 1'b1;
    step("br_ex_hz", mk(RUN, L_FS, 1, 0, 0, 0, 0, 8), 0);
    idle(); step("br_ex_after", mk(LUS, L_ALL, 0, 0, 0, 0, 0, 9), 1);

    // Memory wait takes priority over a hazard; hazard applies on release
    idle(); ex_load_hz(); mem_req = 1'b1;
    step("mw_over_hz", mk(RUN, L_FZ, 0, 0, 0, 0, 0, 9), 0);
    idle(); ex_load_hz(); mem_req = 1'b1; mem_ready = 1'b1;
    step("mw_release_hz", mk(MW, L_FS, 1, 0, 0, 0, 0, 10), 0);
    idle(); step("mw_hz_after", mk(LUS, L_ALL, 0, 0, 0, 0, 0, 11), 1);

    // Timeout: memory never ready, release on the 15th frozen-or-released cycle
    for (int c = 1; c <= 14; c++) begin
      idle(); mem_req = 1'b1;
      step("timeout_wait", mk((c == 1) ? RUN : MW, L_FZ, 0, 0, 0, 0, 0, 16'(c + 10)), 1);
    end
    idle(); mem_req = 1'b1;
    step("timeout_release", mk(MW, L_ALL, 0, 0, 0, 0, 0, 25), 1);
    idle(); step("mem_error_set", mk(RUN, L_ALL, 0, 0, 0, 0, 1, 25), 1);
    idle(); step("mem_error_sticky", mk(RUN, L_ALL, 0, 0, 0, 0, 1, 25), 1);

    // Reset in the middle of a memory wait
    idle(); mem_req = 1'b1; step("pre_reset_wait", mk(RUN, L_FZ, 0, 0, 0, 0, 1, 25), 1);
    idle(); mem_req = 1'b1; step("pre_reset_wait2", mk(MW, L_FZ, 0, 0, 0, 0, 1, 26), 1);
    reset = 1'b1; idle(); mem_req = 1'b1;
    step("reset_in_wait", mk(MW, L_FZ, 1, 0, 0, 0, 1, 27), 1);
    reset = 1'b0; idle();
    step("after_reset", mk(RUN, L_ALL, 0, 0, 0, 0, 0, 0), 1);

    for (int g = 0; g < 10 && exp_q.size() > 0; g++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
